// File: rtl/usb_ctl_router_if.sv
// Control-transfer bus between usb_xfer (up_*) and the request handlers (fn_*).
// The master side is the environment (usb_xfer plus handlers); the slave side is the router.
interface usb_ctl_router_if #(
  parameter int NUM_FUNC = 2
);
  logic                  up_xfer_i;
  logic [7:0]            up_type_i;
  logic [15:0]           up_index_i;
  logic                  up_accept_o;
  logic                  up_done_o;
  logic                  up_data_out_valid_i;
  logic [7:0]            up_data_in_o;
  logic                  up_data_in_valid_o;
  logic                  up_data_in_last_o;
  logic                  up_data_in_ready_i;
  logic [NUM_FUNC-1:0]   fn_xfer_o;
  logic [NUM_FUNC-1:0]   fn_accept_i;
  logic [NUM_FUNC-1:0]   fn_done_i;
  logic [NUM_FUNC-1:0]   fn_data_out_valid_o;
  logic [8*NUM_FUNC-1:0] fn_data_in_i;
  logic [NUM_FUNC-1:0]   fn_data_in_valid_i;
  logic [NUM_FUNC-1:0]   fn_data_in_last_i;
  logic [NUM_FUNC-1:0]   fn_data_in_ready_o;
  logic [3:0]            sel_o;
  logic                  sel_err_o;

  modport master (
    output up_xfer_i, up_type_i, up_index_i, up_data_out_valid_i, up_data_in_ready_i,
           fn_accept_i, fn_done_i, fn_data_in_i, fn_data_in_valid_i, fn_data_in_last_i,
    input  up_accept_o, up_done_o, up_data_in_o, up_data_in_valid_o, up_data_in_last_o,
           fn_xfer_o, fn_data_out_valid_o, fn_data_in_ready_o, sel_o, sel_err_o
  );

  modport slave (
    input  up_xfer_i, up_type_i, up_index_i, up_data_out_valid_i, up_data_in_ready_i,
           fn_accept_i, fn_done_i, fn_data_in_i, fn_data_in_valid_i, fn_data_in_last_i,
    output up_accept_o, up_done_o, up_data_in_o, up_data_in_valid_o, up_data_in_last_o,
           fn_xfer_o, fn_data_out_valid_o, fn_data_in_ready_o, sel_o, sel_err_o
  );
endinterface

// File: rtl/usb_ctl_router.sv
// Routes each USB control transfer to one of NUM_FUNC request handlers with a
// registered channel select, an accept timeout and rejection of unroutable requests.
module usb_ctl_router #(
  parameter int NUM_FUNC       = 2,
  parameter int DEV_CH         = 1,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  usb_ctl_router_if.slave  bus
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_ACC = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;
  localparam logic [1:0] S_REJECT   = 2'd3;
  localparam int CW = (ACCEPT_TIMEOUT < 1) ? 1 : $clog2(ACCEPT_TIMEOUT + 1);

  logic [1:0]          r_state, w_next;
  logic [3:0]          r_sel;
  logic [CW-1:0]       r_cnt;
  logic                r_sel_err;
  logic                w_route_ok;
  logic [3:0]          w_dec_sel;
  logic [8:0]          w_fn_ch;
  logic                w_timeout;
  logic [NUM_FUNC-1:0] w_onehot, w_sel_vec, w_act_vec;
  logic [7:0]          w_data_in;
  logic                w_unused;

  assign w_unused = ^{bus.up_type_i[7], bus.up_index_i[15:8]};
  assign w_fn_ch  = {1'b0, bus.up_index_i[7:0]} + 9'd1;

  always_comb begin
    w_route_ok = 1'b0;
    w_dec_sel  = '0;
    case (bus.up_type_i[6:5])
      2'b00: w_route_ok = 1'b1;
      2'b01, 2'b10: begin
        if (bus.up_type_i[4:0] == 5'd0) begin
          w_route_ok = 1'b1;
          w_dec_sel  = 4'(DEV_CH);
        end else if (bus.up_type_i[4:0] == 5'd1 && w_fn_ch < 9'(NUM_FUNC)) begin
          w_route_ok = 1'b1;
          w_dec_sel  = w_fn_ch[3:0];
        end
      end
      default: w_route_ok = 1'b0;
    endcase
  end

  // Timeout fires on the edge that would bring the count up to ACCEPT_TIMEOUT.
  assign w_timeout = (r_cnt == CW'(ACCEPT_TIMEOUT - 1));
  assign w_onehot  = NUM_FUNC'(1) << r_sel;
  assign w_sel_vec = (r_state == S_WAIT_ACC || r_state == S_ACTIVE) ? w_onehot : '0;
  assign w_act_vec = (r_state == S_ACTIVE) ? w_onehot : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.up_xfer_i) w_next = w_route_ok ? S_WAIT_ACC : S_REJECT;
      S_WAIT_ACC: begin
        if (!bus.up_xfer_i)                         w_next = S_IDLE;
        else if (|(bus.fn_accept_i & w_sel_vec))    w_next = S_ACTIVE;
        else if (w_timeout)                         w_next = S_REJECT;
      end
      default:    if (!bus.up_xfer_i) w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sel_err <= (w_next == S_REJECT) && (r_state != S_REJECT);
      if (r_state == S_IDLE && bus.up_xfer_i)
        r_sel <= w_route_ok ? w_dec_sel : '0;
      if (r_state != S_WAIT_ACC)
        r_cnt <= '0;
      else if (r_cnt != CW'(ACCEPT_TIMEOUT))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_data_in = '0;
    for (int unsigned k = 0; k < NUM_FUNC; k++)
      if (w_sel_vec[k]) w_data_in = bus.fn_data_in_i[8*k +: 8];
  end

  assign bus.up_accept_o         = |(bus.fn_accept_i & w_sel_vec);
  assign bus.up_done_o           = |(bus.fn_done_i & w_act_vec);
  assign bus.up_data_in_o        = w_data_in;
  assign bus.up_data_in_valid_o  = |(bus.fn_data_in_valid_i & w_act_vec);
  assign bus.up_data_in_last_o   = |(bus.fn_data_in_last_i & w_act_vec);
  assign bus.fn_xfer_o           = w_sel_vec;
  assign bus.fn_data_out_valid_o = bus.up_data_out_valid_i ? w_act_vec : '0;
  assign bus.fn_data_in_ready_o  = bus.up_data_in_ready_i ? w_act_vec : '0;
  assign bus.sel_o               = r_sel;
  assign bus.sel_err_o           = r_sel_err;
endmodule

// File: tb/tb_usb_ctl_router.sv
// Directed bench for usb_ctl_router with NUM_FUNC=4, DEV_CH=1, ACCEPT_TIMEOUT=15.
module tb_usb_ctl_router;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  usb_ctl_router_if #(.NUM_FUNC(4)) bus ();

  usb_ctl_router #(.NUM_FUNC(4), .DEV_CH(1), .ACCEPT_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.up_xfer_i           = 1'b0;
    bus.up_type_i           = '0;
    bus.up_index_i          = '0;
    bus.up_data_out_valid_i = 1'b0;
    bus.up_data_in_ready_i  = 1'b0;
    bus.fn_accept_i         = '0;
    bus.fn_done_i           = '0;
    bus.fn_data_in_i        = '0;
    bus.fn_data_in_valid_i  = '0;
    bus.fn_data_in_last_i   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    tick(); tick();
    check("rst_fn_xfer", bus.fn_xfer_o, 4'b0000);
    check("rst_sel", bus.sel_o, 4'd0);
    check("rst_accept", bus.up_accept_o, 1'b0);
    check("rst_sel_err", bus.sel_err_o, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: GET_DESCRIPTOR to channel 0
    bus.up_type_i = 8'h80; bus.up_xfer_i = 1'b1;
    tick();
    check("t1_fn_xfer", bus.fn_xfer_o, 4'b0001);
    check("t1_sel", bus.sel_o, 4'd0);
    check("t1_acc_wait", bus.up_accept_o, 1'b0);
    tick(); tick();
    bus.fn_accept_i = 4'b0001; #1;
    check("t1_acc_pass", bus.up_accept_o, 1'b1);
    tick();
    bus.up_data_in_ready_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.fn_data_in_i       = {8'h00, 8'h00, 8'h55, 8'(8'hA0 + i)};
      bus.fn_data_in_valid_i = 4'b0011;
      bus.fn_data_in_last_i  = (i == 17) ? 4'b0001 : 4'b0010;
      #1;
      check("t1_in_data", bus.up_data_in_o, 8'(8'hA0 + i));
      check("t1_in_valid", bus.up_data_in_valid_o, 1'b1);
      check("t1_in_last", bus.up_data_in_last_o, (i == 17) ? 1'b1 : 1'b0);
      check("t1_in_ready", bus.fn_data_in_ready_o, 4'b0001);
      tick();
    end
    bus.fn_data_in_valid_i = '0; bus.fn_data_in_last_i = '0;
    bus.fn_done_i = 4'b0010; #1;
    check("t1_done_other", bus.up_done_o, 1'b0);
    bus.fn_done_i = 4'b0011; #1;
    check("t1_done", bus.up_done_o, 1'b1);
    bus.up_xfer_i = 1'b0;
    tick();
    check("t1_idle_xfer", bus.fn_xfer_o, 4'b0000);
    check("t1_idle_acc", bus.up_accept_o, 1'b0);
    check("t1_idle_data", bus.up_data_in_o, 8'h00);
    clear_inputs();
    tick();

    // 2: class request to channel 3, OUT strobes
    bus.up_type_i = 8'h21; bus.up_index_i = 16'h0002; bus.up_xfer_i = 1'b1;
    tick();
    check("t2_sel", bus.sel_o, 4'd3);
    check("t2_fn_xfer", bus.fn_xfer_o, 4'b1000);
    bus.fn_accept_i = 4'b1000;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.up_data_out_valid_i = 1'b1; #1;
      check("t2_out_on", bus.fn_data_out_valid_o, 4'b1000);
      bus.up_data_out_valid_i = 1'b0; #1;
      check("t2_out_off", bus.fn_data_out_valid_o, 4'b0000);
      tick();
    end
    clear_inputs();
    tick();

    // 3: out-of-range function index
    bus.up_type_i = 8'h21; bus.up_index_i = 16'h0005; bus.up_xfer_i = 1'b1;
    bus.fn_accept_i = 4'b1111;
    tick();
    check("t3_sel_err", bus.sel_err_o, 1'b1);
    check("t3_acc", bus.up_accept_o, 1'b0);
    check("t3_fn_xfer", bus.fn_xfer_o, 4'b0000);
    tick();
    check("t3_err_pulse", bus.sel_err_o, 1'b0);
    check("t3_fn_xfer2", bus.fn_xfer_o, 4'b0000);
    clear_inputs();
    tick();

    // 4: no accept -> reject after 15 WAIT_ACC cycles
    bus.up_type_i = 8'h80; bus.up_xfer_i = 1'b1;
    tick();
    for (int c = 1; c <= 15; c++) begin
      check("t4_wait", bus.fn_xfer_o, 4'b0001);
      check("t4_no_err", bus.sel_err_o, 1'b0);
      tick();
    end
    check("t4_timeout_xfer", bus.fn_xfer_o, 4'b0000);
    check("t4_timeout_err", bus.sel_err_o, 1'b1);
    clear_inputs();
    tick();

    // 5: drop mid-ACTIVE, re-decode to DEV_CH, reset mid-IN
    bus.up_type_i = 8'h80; bus.up_xfer_i = 1'b1; bus.fn_accept_i = 4'b0001;
    tick(); tick();
    bus.fn_done_i = 4'b0001; #1;
    check("t5_active_done", bus.up_done_o, 1'b1);
    bus.up_xfer_i = 1'b0;
    tick();
    check("t5_drop_xfer", bus.fn_xfer_o, 4'b0000);
    check("t5_drop_done", bus.up_done_o, 1'b0);
    bus.fn_done_i = '0;
    bus.up_type_i = 8'h40; bus.up_xfer_i = 1'b1; bus.fn_accept_i = 4'b0010;
    tick();
    check("t5_dev_sel", bus.sel_o, 4'd1);
    check("t5_dev_xfer", bus.fn_xfer_o, 4'b0010);
    tick();
    bus.fn_data_in_i = 32'h0000_7700; bus.fn_data_in_valid_i = 4'b0010;
    bus.up_data_in_ready_i = 1'b1; #1;
    check("t5_in_data", bus.up_data_in_o, 8'h77);
    check("t5_in_valid", bus.up_data_in_valid_o, 1'b1);
    rst_n = 1'b0; #1;
    check("t5_rst_data", bus.up_data_in_o, 8'h00);
    check("t5_rst_valid", bus.up_data_in_valid_o, 1'b0);
    check("t5_rst_xfer", bus.fn_xfer_o, 4'b0000);
    check("t5_rst_ready", bus.fn_data_in_ready_o, 4'b0000);
    check("t5_rst_sel", bus.sel_o, 4'd0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    // 6: accept on the timeout cycle wins
    bus.up_type_i = 8'h80; bus.up_xfer_i = 1'b1;
    tick();
    for (int c = 1; c < 15; c++) tick();
    bus.fn_accept_i = 4'b0001;
    tick();
    check("t6_active_xfer", bus.fn_xfer_o, 4'b0001);
    check("t6_no_err", bus.sel_err_o, 1'b0);
    check("t6_acc", bus.up_accept_o, 1'b1);
    tick();
    check("t6_stay_xfer", bus.fn_xfer_o, 4'b0001);
    check("t6_stay_err", bus.sel_err_o, 1'b0);
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
